// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared defaults and helpers for the parametrised ID-stage register file.
//   - DEF_LARGURA_DADO / DEF_NUM_REGS / DEF_PORTAS_LEITURA: default geometry
//   - addr_width(n): address width needed to index n registers (at least 1)
package reg_file_pkg;

  localparam int DEF_LARGURA_DADO   = 32;
  localparam int DEF_NUM_REGS       = 32;
  localparam int DEF_PORTAS_LEITURA = 2;

  // $clog2(1) is 0, which would produce zero-width address buses, so clamp to 1.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Pending-write scoreboard: one busy bit per architectural register plus a
//   count of how many are currently busy. Issue reserves a destination,
//   writeback releases it; a same-cycle reserve wins over a release.
// Ports
//   clk                in  rising-edge clock
//   reset              in  asynchronous active-high clear
//   habilita_reserva   in  reserve strobe (issue)
//   endereco_reserva   in  register to reserve
//   habilita_escrita   in  write strobe (writeback), releases endereco_destino
//   endereco_destino   in  register being written
//   ocupado            out busy vector, bit r = register r has a pending write
//   contagem_pendentes out number of busy registers
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter bit ZERO_FIXO = 1'b1,
  localparam int AW = addr_width(NUM_REGS),
  localparam int CW = $clog2(NUM_REGS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                habilita_reserva,
  input  logic [AW-1:0]       endereco_reserva,
  input  logic                habilita_escrita,
  input  logic [AW-1:0]       endereco_destino,
  output logic [NUM_REGS-1:0] ocupado,
  output logic [CW-1:0]       contagem_pendentes
);

  localparam logic [CW-1:0] CONTAGEM_MAX = CW'(NUM_REGS - int'(ZERO_FIXO));

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic [CW-1:0]       count_reg;
  logic [CW-1:0]       count_next;
  logic                sobe;
  logic                desce;

  // Out-of-range addresses decode to no bit, so they are ignored for free.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
    localparam bit VALIDO = !(ZERO_FIXO && gi == 0);
    assign set_vec[gi] = VALIDO && habilita_reserva && (endereco_reserva == AW'(gi));
    assign clr_vec[gi] = VALIDO && habilita_escrita && (endereco_destino == AW'(gi));
  end

  // Set has priority: a reserve alongside a write to the same register means a
  // younger producer is now in flight, so the bit must stay high.
  assign busy_next = set_vec | (busy_reg & ~clr_vec);

  // At most one bit can rise and one can fall per cycle.
  assign sobe  = |(set_vec & ~busy_reg);
  assign desce = |(clr_vec & busy_reg & ~set_vec);

  always_comb begin
    count_next = count_reg;
    if (sobe && !desce && count_reg != CONTAGEM_MAX) begin
      count_next = count_reg + 1'b1;
    end else if (desce && !sobe && count_reg != '0) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg  <= '0;
      count_reg <= '0;
    end else begin
      busy_reg  <= busy_next;
      count_reg <= count_next;
    end
  end

  assign ocupado            = busy_reg;
  assign contagem_pendentes = count_reg;

endmodule

// File: rtl/register_file_param.sv
// register_file_param
//   Parametrised ID-stage register file: PORTAS_LEITURA combinational read
//   ports, one synchronous write port, optional same-cycle write bypass,
//   optional hardwired-zero register 0, and a pending-write scoreboard that
//   flags read sources still waiting on writeback.
// Ports
//   clk                in  rising-edge clock
//   reset              in  asynchronous active-high clear of data and scoreboard
//   habilita_escrita   in  write enable (writeback)
//   endereco_destino   in  write address
//   dado_escrita       in  write data
//   enderecos_fonte    in  packed read addresses, port p = [p*AW +: AW]
//   dados_fonte        out packed read data, port p = [p*LARGURA_DADO +: LARGURA_DADO]
//   habilita_reserva   in  reserve endereco_reserva (issue)
//   endereco_reserva   in  register to reserve
//   ocupado_fonte      out bit p = source p has a pending write
//   contagem_pendentes out number of registers currently reserved
module register_file_param
  import reg_file_pkg::*;
#(
  parameter int LARGURA_DADO   = DEF_LARGURA_DADO,
  parameter int NUM_REGS       = DEF_NUM_REGS,
  parameter int PORTAS_LEITURA = DEF_PORTAS_LEITURA,
  parameter bit BYPASS         = 1'b1,
  parameter bit ZERO_FIXO      = 1'b1,
  localparam int AW = addr_width(NUM_REGS),
  localparam int CW = $clog2(NUM_REGS + 1)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   habilita_escrita,
  input  logic [AW-1:0]                          endereco_destino,
  input  logic [LARGURA_DADO-1:0]                dado_escrita,
  input  logic [PORTAS_LEITURA*AW-1:0]           enderecos_fonte,
  output logic [PORTAS_LEITURA*LARGURA_DADO-1:0] dados_fonte,
  input  logic                                   habilita_reserva,
  input  logic [AW-1:0]                          endereco_reserva,
  output logic [PORTAS_LEITURA-1:0]              ocupado_fonte,
  output logic [CW-1:0]                          contagem_pendentes
);

  logic [LARGURA_DADO-1:0] regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0]     ocupado_vec;
  logic                    escrita_valida;

  // A write that lands nowhere (out of range, or the hardwired zero) is
  // dropped here so neither the array nor the bypass ever sees it.
  assign escrita_valida = habilita_escrita
                       && (int'(endereco_destino) < NUM_REGS)
                       && !(ZERO_FIXO && endereco_destino == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (escrita_valida) begin
      regs_reg[endereco_destino] <= dado_escrita;
    end
  end

  reg_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .ZERO_FIXO (ZERO_FIXO)
  ) u_scoreboard (
    .clk                (clk),
    .reset              (reset),
    .habilita_reserva   (habilita_reserva),
    .endereco_reserva   (endereco_reserva),
    .habilita_escrita   (habilita_escrita),
    .endereco_destino   (endereco_destino),
    .ocupado            (ocupado_vec),
    .contagem_pendentes (contagem_pendentes)
  );

  for (genvar gi = 0; gi < PORTAS_LEITURA; gi++) begin : g_porta
    logic [AW-1:0]           fonte;
    logic                    fonte_valida;
    logic                    acerto_bypass;
    logic                    reserva_mesma;
    logic [LARGURA_DADO-1:0] valor_array;

    assign fonte        = enderecos_fonte[gi*AW +: AW];
    assign fonte_valida = (int'(fonte) < NUM_REGS) && !(ZERO_FIXO && fonte == '0);
    assign valor_array  = fonte_valida ? regs_reg[fonte] : '0;

    // Bypass is gated by reset so the outputs read zero while reset is held,
    // even if the write port is being driven.
    assign acerto_bypass = BYPASS && !reset && escrita_valida && (endereco_destino == fonte);
    assign reserva_mesma = habilita_reserva && (endereco_reserva == fonte);

    assign dados_fonte[gi*LARGURA_DADO +: LARGURA_DADO] =
      acerto_bypass ? dado_escrita : valor_array;

    // A forwarded write satisfies the hazard unless a new producer for the
    // same register is being issued in the very same cycle.
    assign ocupado_fonte[gi] = fonte_valida && ocupado_vec[fonte]
                            && !(acerto_bypass && !reserva_mesma);
  end

endmodule
